// File: rtl/boot_loader.sv
// Byte-stream boot loader: loads a length-prefixed, XOR-checksummed image into instruction ROM,
// then releases the CPU reset. Optional inter-byte timeout enabled by defining BOOT_TIMEOUT_EN.

`ifndef RstEnable
`define RstEnable 1'b1
`endif
`ifndef RstDisable
`define RstDisable 1'b0
`endif

module boot_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [31:0]       rom_wdata_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned CntW     = ADDR_W + 1;
    localparam logic [31:0] MaxWords = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StRun,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [CntW-1:0]   word_cnt_q, word_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [23:0]       asm_q, asm_d;
    logic              rx_ready_q, rx_ready_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [31:0]       rom_wdata_q, rom_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [15:0]       len_full;
    logic              last_word;

`ifdef BOOT_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
`endif

    assign accept    = rx_valid_i & rx_ready_q;
    assign len_full  = {len_q[15:8], rx_data_i};
    assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(len_q);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_idx_d  = byte_idx_q;
        csum_d      = csum_q;
        asm_d       = asm_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;

        unique case (state_q)
            StLenHi: begin
                if (accept) begin
                    len_d[15:8] = rx_data_i;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d = len_full;
                    if (32'(len_full) > MaxWords) begin
                        state_d = StErr;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    asm_d      = {asm_q[15:0], rx_data_i};
                    csum_d     = csum_q ^ rx_data_i;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        rom_we_d    = 1'b1;
                        rom_wdata_d = {asm_q, rx_data_i};
                        rom_addr_d  = word_cnt_q[ADDR_W-1:0];
                        word_cnt_d  = word_cnt_q + 1'b1;
                        if (last_word) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (rx_data_i == csum_q) ? StRun : StErr;
                end
            end
            StRun, StErr: begin
            end
            default: state_d = StErr;
        endcase

`ifdef BOOT_TIMEOUT_EN
        tmo_d = '0;
        if (state_q inside {StLenLo, StData, StCsum} && !accept) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TmoW'(TIMEOUT_CYC)) begin
                state_d = StErr;
            end
        end
`endif

        // Outputs are registered, so they are derived from the next state.
        rx_ready_d = state_d inside {StLenHi, StLenLo, StData, StCsum};
        done_d     = done_q | (state_d == StRun);
        err_d      = err_q | (state_d == StErr);
        cpu_rst_d  = (state_d == StRun) ? `RstDisable : `RstEnable;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StLenHi;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            csum_q      <= '0;
            asm_q       <= '0;
            rx_ready_q  <= 1'b0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            cpu_rst_q   <= `RstEnable;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_idx_q  <= byte_idx_d;
            csum_q      <= csum_d;
            asm_q       <= asm_d;
            rx_ready_q  <= rx_ready_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef BOOT_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign rx_ready_o  = rx_ready_q;
    assign rom_we_o    = rom_we_q;
    assign rom_addr_o  = rom_addr_q;
    assign rom_wdata_o = rom_wdata_q;
    assign cpu_rst_o   = cpu_rst_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomised self-checking bench for boot_loader; images are parsed by a byte-level model
// and the ROM writes, completion flags and CPU reset are compared against it.

module tb_boot_loader;

    localparam int unsigned AW  = 10;
    localparam int unsigned TMO = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_wdata;
    logic          cpu_rst;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    boot_loader #(
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TMO)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .rx_ready_o  (rx_ready),
        .rom_we_o    (rom_we),
        .rom_addr_o  (rom_addr),
        .rom_wdata_o (rom_wdata),
        .cpu_rst_o   (cpu_rst),
        .done_o      (done),
        .err_o       (err)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Image under test, the model's expected writes, and the writes observed on the ROM port.
    logic [7:0]     img_q[$];
    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] got_q[$];
    bit             exp_done;
    bit             exp_err;
    int             n_send;

    logic xfer_q    = 1'b0;
    logic we_prev   = 1'b0;
    int   lat_bad   = 0;
    int   twice_bad = 0;

    always @(posedge clk) xfer_q <= rx_valid & rx_ready;

    always @(negedge clk) begin
        if (rom_we) begin
            got_q.push_back({rom_addr, rom_wdata});
            if (!xfer_q) lat_bad <= lat_bad + 1;
            if (we_prev) twice_bad <= twice_bad + 1;
        end
        we_prev <= rom_we;
    end

    // Parse the image as the format defines it: 16-bit length, big-endian words, XOR checksum.
    task automatic model_image();
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        x = 8'h00;
        n = int'({img_q[0], img_q[1]});
        if (n > (1 << AW)) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            n_send   = 2;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = {img_q[2+4*i], img_q[3+4*i], img_q[4+4*i], img_q[5+4*i]};
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            exp_q.push_back({AW'(i), w});
        end
        n_send   = 2 + 4 * n + 1;
        exp_done = (img_q[2+4*n] == x);
        exp_err  = !exp_done;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_rx_ready"}, rx_ready, 0);
        check_eq({tag, "_rom_we"}, rom_we, 0);
        check_eq({tag, "_rom_addr"}, rom_addr, 0);
        check_eq({tag, "_rom_wdata"}, rom_wdata, 0);
        check_eq({tag, "_cpu_rst"}, cpu_rst, 1);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst_n    = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", rx_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        int g;
        g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
        repeat (g) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        w = 0;
        while (!rx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) check_eq("rx_ready_wait", rx_ready, 1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input int gap);
        model_image();
        got_q.delete();
        for (int i = 0; i < n_send; i++) begin
            if (i == n_send - 1) begin
                @(negedge clk);
                check_eq({tag, "_pre_done"}, done, 0);
                check_eq({tag, "_pre_err"}, err, 0);
                send_byte(img_q[i], 0);
            end else begin
                send_byte(img_q[i], gap);
            end
        end
        @(negedge clk);
        check_eq({tag, "_done"}, done, exp_done);
        check_eq({tag, "_err"}, err, exp_err);
        check_eq({tag, "_cpu_rst"}, cpu_rst, exp_done ? 0 : 1);
        check_eq({tag, "_ready_off"}, rx_ready, 0);
        // Terminal states must ignore further traffic.
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        repeat (8) @(negedge clk);
        rx_valid = 1'b0;
        check_eq({tag, "_term_ready"}, rx_ready, 0);
        check_eq({tag, "_term_done"}, done, exp_done);
        check_eq({tag, "_n_writes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq({tag, "_rom_wr"}, got_q[i], exp_q[i]);
        end
    endtask

    task automatic load_case1(input logic [7:0] csum);
        img_q = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        img_q.push_back(csum);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         n;
        logic [7:0] x;
        logic [7:0] b;

        // Case 1: good two-word image.
        do_reset();
        load_case1(8'h24);
        run_load("case1", 0);

        // Case 2: checksum mismatch.
        do_reset();
        load_case1(8'h25);
        run_load("case2", 0);

        // Case 3: empty image, then an oversize length.
        do_reset();
        img_q = '{8'h00, 8'h00, 8'h00};
        run_load("empty", 0);
        do_reset();
        img_q = '{8'h04, 8'h01};
        run_load("oversize", 0);

        // Case 4: valid toggling 1-0-0-1.
        do_reset();
        load_case1(8'h24);
        run_load("gaps", 2);

        // Case 5: reset pulse part way through, then a full reload.
        do_reset();
        load_case1(8'h24);
        for (int i = 0; i < 5; i++) send_byte(img_q[i], 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_load("reload", -1);

        // Case 6: long idle after a partial image.
        do_reset();
        load_case1(8'h24);
        for (int i = 0; i < 3; i++) send_byte(img_q[i], 0);
`ifdef BOOT_TIMEOUT_EN
        repeat (TMO - 1) @(posedge clk);
        @(negedge clk);
        check_eq("tmo_early", err, 0);
        @(negedge clk);
        check_eq("tmo_err", err, 1);
        check_eq("tmo_cpu_rst", cpu_rst, 1);
        check_eq("tmo_ready", rx_ready, 0);
`else
        repeat (10000) @(negedge clk);
        check_eq("idle_err", err, 0);
        check_eq("idle_ready", rx_ready, 1);
        for (int i = 3; i < 11; i++) send_byte(img_q[i], 0);
        @(negedge clk);
        check_eq("idle_done", done, 1);
        check_eq("idle_cpu_rst", cpu_rst, 0);
`endif

        // Largest legal image: every ROM word, back-to-back bytes.
        do_reset();
        img_q.delete();
        img_q.push_back(8'h04);
        img_q.push_back(8'h00);
        x = 8'h00;
        for (int i = 0; i < 4 * (1 << AW); i++) begin
            b = 8'($urandom);
            x ^= b;
            img_q.push_back(b);
        end
        img_q.push_back(x);
        run_load("full_rom", 0);

        // Random images, some corrupt or oversize.
        for (int r = 0; r < 12; r++) begin
            do_reset();
            img_q.delete();
            if ($urandom_range(7, 0) == 0) begin
                n = int'($urandom_range(65535, (1 << AW) + 1));
                img_q.push_back(8'(n >> 8));
                img_q.push_back(8'(n));
            end else begin
                n = int'($urandom_range(6, 0));
                img_q.push_back(8'(n >> 8));
                img_q.push_back(8'(n));
                x = 8'h00;
                for (int i = 0; i < 4 * n; i++) begin
                    b = 8'($urandom);
                    x ^= b;
                    img_q.push_back(b);
                end
                if ($urandom_range(3, 0) == 0) x ^= 8'($urandom_range(255, 1));
                img_q.push_back(x);
            end
            run_load("rand", -1);
        end

        check_eq("we_latency", lat_bad, 0);
        check_eq("we_back_to_back", twice_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
Byte-stream boot loader directly upstream of openmips_min_sopc. Receives a length-prefixed program image over a valid/ready byte interface and writes it word-by-word into instruction ROM. Holds the CPU in reset until the image is loaded and its checksum verifies, then releases it. It replaces the bench-driven reset with a hardware-sequenced one.

Parameters:
ADDR_W, 10, ROM word-address width; capacity 2^ADDR_W words
TIMEOUT_CYC, 65535, inter-byte timeout in clk cycles (used only with BOOT_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_valid  in  1  byte available on rx_data
rx_data  in  8  incoming byte
rx_ready  out  1  loader accepts byte; transfer = rx_valid & rx_ready on rising clk
rom_we  out  1  one-cycle ROM write strobe
rom_addr  out  ADDR_W  ROM word address
rom_wdata  out  32  ROM write data
cpu_rst  out  1  drives the SOPC rst input; held at `RstEnable until load succeeds, then `RstDisable
done  out  1  image loaded and verified (sticky)
err  out  1  load failed (sticky until rst)

Behaviour:
- Reset (rst=0, async): state S_LEN_HI; rx_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, cpu_rst=`RstEnable, done=0, err=0; word count, byte index, checksum cleared.
- All outputs registered. rx_ready goes to 1 on the first clk edge after rst deasserts and stays 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM; 0 in S_RUN and S_ERR.
- Image format: N[15:8], N[7:0], then N words as 4 bytes each, big-endian (first byte = bits 31:24), then 1 checksum byte = XOR of all 4N payload bytes. Length bytes are excluded from the checksum.
- S_LEN_HI: accept byte -> N_hi, go S_LEN_LO.
- S_LEN_LO: accept byte -> N_lo.
  - N > 2^ADDR_W: go S_ERR.
  - N == 0: go S_CSUM.
  - Otherwise: go S_DATA.
- S_DATA: shift each accepted byte into a 32-bit assembly register and XOR it into the checksum; 2-bit byte index.
  - On the 4th byte: next cycle rom_we=1, rom_wdata=assembled word, rom_addr=word index; word index += 1.
  - Latency from last byte accepted to rom_we = 1 cycle. rom_we is never high two consecutive cycles, since each byte needs its own handshake.
  - After word N-1 is written: go S_CSUM.
  - Word counter is ADDR_W+1 bits, so N=2^ADDR_W is legal; rom_addr wraps to 0 only after the final write and is not used again.
- S_CSUM: accept byte.
  - Equal to running XOR: go S_RUN; next cycle done=1, cpu_rst=`RstDisable.
  - Not equal: go S_ERR; err=1, cpu_rst stays `RstEnable.
- S_RUN and S_ERR are terminal. rx_valid is ignored and rom_we stays 0. Only rst exits them.
- rx_valid=0 gaps of any length are legal and do not affect state (unless the timeout feature is enabled).
- rst asserted mid-load: immediate return to reset values. The partial ROM contents are left as-is and are overwritten by the next load.

Optional Feature:
BOOT_TIMEOUT_EN:
- Defined: a counter of width clog2(TIMEOUT_CYC+1) runs in S_LEN_LO, S_DATA and S_CSUM. It clears on every accepted byte. Reaching TIMEOUT_CYC forces S_ERR and err=1. S_LEN_HI never times out, so the loader can wait for the first byte indefinitely.
- Undefined: no counter; the loader waits indefinitely in every state.

Test Plan:
1. Bytes 00 02 34 01 11 00 00 00 00 00 24 -> rom_we twice: addr0=0x34011100, then addr1=0x00000000; done=1 and cpu_rst=`RstDisable one cycle after byte 0x24 is accepted; err=0.
2. Same image with checksum byte 0x25 -> both ROM writes occur; err=1, done=0, cpu_rst stays `RstEnable; later bytes ignored, rx_ready=0.
3. Bytes 00 00 00 -> no rom_we; done=1. With ADDR_W=10, bytes 04 01 -> err=1 right after the 2nd byte, no writes.
4. Case 1 with rx_valid toggling 1-0-0-1 between bytes -> identical ROM writes and completion, only delayed.
5. rst pulsed low after 5 bytes of case 1, then case 1 resent in full -> all outputs return to reset values during the pulse; second load completes with done=1.
6. BOOT_TIMEOUT_EN, TIMEOUT_CYC=100: send 00 02 34, then idle -> err=1 exactly 100 cycles after 0x34 is accepted. Without the macro, no err after 10000 idle cycles.
